// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared constants for the bit-serial subtractor:
//   - FSM state encodings (IDLE / SHIFT / FINISH)
//   - default operand width
//   - bit-counter width rule (clog2 of the operand width)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam int DEFAULT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // The counter only has to reach W-1, so clog2(W) bits suffice for W >= 2.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Request/response bundle of the bit-serial subtractor.
//   start  : request, honoured only while busy = 0
//   a, b   : minuend / subtrahend (W bits), captured on accepted start
//   bin    : borrow-in, captured on accepted start
//   busy   : operation in flight
//   done   : one-cycle pulse, diff valid
//   diff   : {borrow-out, difference} (W+1 bits)
// master = requester, slave = subtractor.
// -----------------------------------------------------------------------------
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int W = DEFAULT_W
);

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W:0]   diff;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Combinational 1-bit subtract cell: {bo, d} = x - y - bi.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    // Borrow when y exceeds x outright, or when they are equal and a borrow
    // is already pending.
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial W-bit subtractor, LSB first: {bout, d} = a - b - bin.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (clears all state)
//   bus : serial_subtractor_if.slave (start/a/b/bin in, busy/done/diff out)
// Timing: start sampled at edge E0, W SHIFT edges, one FINISH cycle, and the
// registered done pulse is seen in the cycle after edge E0+W+1. One operation
// per W+2 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int              CW   = cnt_width(W);
    localparam logic [CW-1:0]   LAST = CW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          br_q, br_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    diff_q, diff_d;
    logic          done_q, done_d;

    logic dbit;
    logic bo;

    full_subtractor u_fs (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (br_q),
        .d  (dbit),
        .bo (bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // New bit enters at the MSB so after W shifts bit 0 holds the LSB.
                res_d = {dbit, {(W-1){1'b0}}} | (res_q >> 1);
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // diff only changes here, so it stays stable during SHIFT.
                    diff_d  = {bo, res_d};
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                // done is registered, so the pulse lands in the cycle after FINISH.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.diff = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed, table-driven bench for serial_subtractor (W = 4). Inputs are
// driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.W(W)) bus ();

    serial_subtractor #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one request and check done arrives exactly 5 cycles after the
    // start edge with the expected result. Ends in the done cycle.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                          input logic [4:0] exp, input string name);
        logic early;
        early     = 1'b0;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.bin   = tbin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 5 && bus.done) early = 1'b1;
        end
        check({name, " early_done"}, {31'd0, early}, 32'd0);
        check({name, " done"}, {31'd0, bus.done}, 32'd1);
        check({name, " diff"}, {27'd0, bus.diff}, {27'd0, exp});
    endtask

    initial begin
        logic seen;
        logic [4:0] ref_v;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 4'd5;
        bus.b     = 4'd1;
        bus.bin   = 1'b0;

        vecs[0] = '{4'd10, 4'd2,  1'b1, 5'b00111, "a10_b2_bin1"};
        vecs[1] = '{4'd8,  4'd3,  1'b1, 5'b00100, "a8_b3_bin1"};
        vecs[2] = '{4'd6,  4'd7,  1'b0, 5'b11111, "a6_b7_bin0"};
        vecs[3] = '{4'd0,  4'd0,  1'b1, 5'b11111, "a0_b0_bin1"};
        vecs[4] = '{4'd15, 4'd15, 1'b0, 5'b00000, "a15_b15_bin0"};
        vecs[5] = '{4'd15, 4'd0,  1'b0, 5'b01111, "a15_b0_bin0"};

        // Reset held two cycles with start asserted
        tick();
        tick();
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset diff", {27'd0, bus.diff}, 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("start_in_reset busy", {31'd0, bus.busy}, 32'd0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            tick();
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, vecs[i].name);
        end
        tick();
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);

        // Extra requests in SHIFT and FINISH are dropped
        bus.a = 4'd9; bus.b = 4'd4; bus.bin = 1'b0; bus.start = 1'b1;
        tick();
        bus.a = 4'd1; bus.b = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("ignore finish busy", {31'd0, bus.busy}, 32'd1);
        check("ignore finish done", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ignore done", {31'd0, bus.done}, 32'd1);
        check("ignore diff", {27'd0, bus.diff}, 32'd5);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("ignore dropped", {31'd0, seen}, 32'd0);

        // Back-to-back: new start in the cycle after done
        run_op(4'd3, 4'd1, 1'b0, 5'b00010, "b2b_first");
        tick();
        run_op(4'd5, 4'd9, 1'b1, 5'b11011, "b2b_second");

        // Reset mid-operation
        tick();
        bus.a = 4'd12; bus.b = 4'd5; bus.bin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst diff", {27'd0, bus.diff}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check("midrst no_done", {31'd0, seen}, 32'd0);
        run_op(4'd12, 4'd5, 1'b0, 5'b00111, "after_rst");

        // Exhaustive sweep against the reference expression
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    ref_v = 5'(ia - ib - ic);
                    tick();
                    run_op(4'(ia), 4'(ib), ic[0], ref_v, "sweep");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
